// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one signed 4x4 multiplier between two requesters,
// with registered outputs, timeout abort and a valid/ready tagged response.
module mult_share_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   output logic       gnt1,
   output logic [3:0] mul_a,
   output logic [3:0] mul_b,
   output logic       mul_start,
   input  logic       mul_done,
   input  logic [7:0] mul_c,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
   state_t state, nstate;
   logic last, owner, pick, grant;
   logic [CNT_W-1:0] cnt;
   // last holds the id served most recently; reset to 1 so requester 0 is favoured
   always_comb begin
      pick = req1 & (~req0 | ~last);
      grant = (state == IDLE) & (req0 | req1);
      nstate = state;
      case (state)
         IDLE: nstate = grant ? START : IDLE;
         START: nstate = WAIT;
         WAIT: nstate = (mul_done || cnt == CNT_W'(TIMEOUT - 1)) ? RESP : WAIT;
         RESP: nstate = rsp_ready ? IDLE : RESP;
         default: nstate = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last <= 1'b1;
         owner <= 1'b0;
         cnt <= '0;
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         mul_a <= '0;
         mul_b <= '0;
         mul_start <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id <= 1'b0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= nstate;
         busy <= nstate != IDLE;
         gnt0 <= grant & ~pick;
         gnt1 <= grant & pick;
         mul_start <= grant;
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
         if (grant) begin
            mul_a <= pick ? a1 : a0;
            mul_b <= pick ? b1 : b0;
            owner <= pick;
         end
         if (state == WAIT && nstate == RESP) begin
            rsp_valid <= 1'b1;
            rsp_err <= ~mul_done;
            rsp_data <= mul_done ? mul_c : '0;
            rsp_id <= owner;
         end
         if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            last <= owner;
         end
      end
   end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed and randomized checks of mult_share_ctrl against a
// 9-cycle multiplier stub and a transaction-level round-robin/product model.
module tb_mult_share_ctrl;
   localparam int TIMEOUT = 15;
   logic clk, rst, req0, req1, gnt0, gnt1, mul_start, mul_done, rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [3:0] a0, b0, a1, b1, mul_a, mul_b;
   logic [7:0] mul_c, rsp_data;
   int checks = 0, failures = 0, dcnt = 0;
   logic dead = 0, spur = 0;
   logic [7:0] spur_c = 0;

   mult_share_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
      .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .mul_a(mul_a), .mul_b(mul_b),
      .mul_start(mul_start), .mul_done(mul_done), .mul_c(mul_c), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // multiplier stub: done pulse 9 cycles after the start cycle, product of live operands
   always @(negedge clk) begin
      if (rst) dcnt <= 0;
      else if (mul_start) dcnt <= 9;
      else if (dcnt > 0) dcnt <= dcnt - 1;
      mul_done <= ~rst & ((dcnt == 1 && !mul_start && !dead) | spur);
      mul_c <= spur ? spur_c : 8'($signed(mul_a) * $signed(mul_b));
   end

   function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      return 8'(sa * sb);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (!(gnt0 === 1'b1 || gnt1 === 1'b1) && n < 40) begin
         tick;
         n++;
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick;
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1; req0 = 1; req1 = 1;
      tick;
      checks++;
      if ({gnt0, gnt1, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {gnt0, gnt1, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_data, rsp_err, busy});
      end
      tick;
      checks++;
      if ({gnt0, gnt1, mul_start, busy} !== 0) begin
         failures++;
         $display("FAIL reset_hold got=%b exp=0000", {gnt0, gnt1, mul_start, busy});
      end
      rst = 0; req0 = 0; req1 = 0;
   endtask

   task automatic test_single;
      int n;
      rst = 1; tick; rst = 0;
      rsp_ready = 1; req0 = 1; a0 = 4'b1101; b0 = 4'b0101;
      tick;
      checks++;
      if ({gnt0, gnt1, mul_start, busy} !== 4'b1011) begin
         failures++;
         $display("FAIL single_gnt got=%b exp=1011", {gnt0, gnt1, mul_start, busy});
      end
      checks++;
      if ({mul_a, mul_b} !== 8'hD5) begin
         failures++;
         $display("FAIL single_operands got=%h exp=d5", {mul_a, mul_b});
      end
      req0 = 0;
      wait_valid(n);
      checks++;
      if (n != 10) begin
         failures++;
         $display("FAIL single_latency got=%0d exp=10", n);
      end
      checks++;
      if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 8'hF1}) begin
         failures++;
         $display("FAIL single_rsp got=%h exp=0f1", {rsp_id, rsp_err, rsp_data});
      end
      tick;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL single_accept got=%b exp=00", {busy, rsp_valid});
      end
   endtask

   task automatic test_both;
      int n;
      bit e;
      rst = 1; req0 = 1; req1 = 1; a0 = 4'd7; b0 = 4'd7; a1 = 4'h8; b1 = 4'h8; rsp_ready = 1;
      tick;
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         e = k[0];
         wait_gnt(n);
         checks++;
         if (n != 1 || {gnt0, gnt1} !== (e ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL both_gnt%0d got=%b after %0d exp=%b after 1", k, {gnt0, gnt1}, n, e ? 2'b01 : 2'b10);
         end
         if (k == 3) begin
            req0 = 0; req1 = 0;
         end
         wait_valid(n);
         checks++;
         if ({rsp_id, rsp_err, rsp_data} !== {e, 1'b0, e ? 8'h40 : 8'h31}) begin
            failures++;
            $display("FAIL both_rsp%0d got=%h exp=%h", k, {rsp_id, rsp_err, rsp_data}, {e, 1'b0, e ? 8'h40 : 8'h31});
         end
         tick;
      end
   endtask

   task automatic test_hold;
      int n;
      logic [9:0] v;
      rsp_ready = 0; req0 = 1; a0 = 4'd3; b0 = 4'hE;
      tick;
      checks++;
      if (gnt0 !== 1'b1) begin
         failures++;
         $display("FAIL hold_gnt0 got=%b exp=1", gnt0);
      end
      req0 = 0; req1 = 1; a1 = 4'd5; b1 = 4'd3;
      wait_valid(n);
      v = {rsp_id, rsp_err, rsp_data};
      checks++;
      if (v !== {1'b0, 1'b0, 8'hFA}) begin
         failures++;
         $display("FAIL hold_rsp got=%h exp=0fa", v);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, v} || {gnt0, gnt1, busy} !== 3'b001) begin
            failures++;
            $display("FAIL hold_stable%0d got=%h/%b exp=%h/001", i, {rsp_valid, rsp_id, rsp_err, rsp_data}, {gnt0, gnt1, busy}, {1'b1, v});
         end
      end
      rsp_ready = 1;
      tick;
      checks++;
      if ({gnt1, busy, rsp_valid} !== 3'b000) begin
         failures++;
         $display("FAIL hold_idle got=%b exp=000", {gnt1, busy, rsp_valid});
      end
      tick;
      checks++;
      if (gnt1 !== 1'b1) begin
         failures++;
         $display("FAIL hold_gnt1 got=%b exp=1", gnt1);
      end
      req1 = 0;
      wait_valid(n);
      checks++;
      if ({rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b0, 8'h0F}) begin
         failures++;
         $display("FAIL hold_rsp1 got=%h exp=20f", {rsp_id, rsp_err, rsp_data});
      end
      tick;
   endtask

   task automatic test_timeout;
      int n;
      dead = 1; rsp_ready = 1; req1 = 1; a1 = 4'd2; b1 = 4'd3;
      tick;
      checks++;
      if (gnt1 !== 1'b1) begin
         failures++;
         $display("FAIL to_gnt1 got=%b exp=1", gnt1);
      end
      req1 = 0;
      wait_valid(n);
      checks++;
      if (n != TIMEOUT + 1) begin
         failures++;
         $display("FAIL to_latency got=%0d exp=%0d", n, TIMEOUT + 1);
      end
      checks++;
      if ({rsp_id, rsp_err, rsp_data} !== {1'b1, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL to_rsp got=%h exp=300", {rsp_id, rsp_err, rsp_data});
      end
      tick;
      dead = 0; req0 = 1; a0 = 4'hF; b0 = 4'hF;
      tick;
      req0 = 0;
      wait_valid(n);
      checks++;
      if (n != 10 || {rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 8'h01}) begin
         failures++;
         $display("FAIL to_recover got=%h after %0d exp=001 after 10", {rsp_id, rsp_err, rsp_data}, n);
      end
      tick;
   endtask

   task automatic test_reset_wait;
      int n;
      rsp_ready = 1; req0 = 1; a0 = 4'd6; b0 = 4'd2;
      tick;
      req0 = 0;
      repeat (3) tick;
      rst = 1;
      tick;
      checks++;
      if ({gnt0, gnt1, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 0) begin
         failures++;
         $display("FAIL rstw_outputs got=%h exp=0", {gnt0, gnt1, mul_a, mul_b, mul_start, rsp_valid, rsp_id, rsp_data, rsp_err, busy});
      end
      rst = 0; spur = 1; spur_c = 8'h5A;
      tick;
      spur = 0;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL rstw_stale got=%b exp=00", {busy, rsp_valid});
      end
      req0 = 1; req1 = 1; a1 = 4'd1; b1 = 4'd1;
      tick;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         failures++;
         $display("FAIL rstw_rr got=%b exp=10", {gnt0, gnt1});
      end
      req0 = 0; req1 = 0;
      wait_valid(n);
      checks++;
      if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 8'h0C}) begin
         failures++;
         $display("FAIL rstw_rsp got=%h exp=00c", {rsp_id, rsp_err, rsp_data});
      end
      tick;
   endtask

   task automatic test_spurious;
      int n;
      spur = 1; spur_c = 8'hA5;
      tick;
      spur = 0;
      tick;
      checks++;
      if ({gnt0, gnt1, busy, rsp_valid} !== 4'b0000) begin
         failures++;
         $display("FAIL spur_idle got=%b exp=0000", {gnt0, gnt1, busy, rsp_valid});
      end
      rsp_ready = 0; req0 = 1; a0 = 4'hC; b0 = 4'd3;
      tick;
      req0 = 0; a0 = 4'h1; b0 = 4'h7;
      wait_valid(n);
      checks++;
      if ({rsp_id, rsp_err, rsp_data} !== {1'b0, 1'b0, 8'hF4}) begin
         failures++;
         $display("FAIL spur_capture got=%h exp=0f4", {rsp_id, rsp_err, rsp_data});
      end
      spur = 1;
      tick;
      spur = 0;
      tick;
      checks++;
      if ({rsp_valid, busy, rsp_id, rsp_err, rsp_data} !== {4'b1100, 8'hF4}) begin
         failures++;
         $display("FAIL spur_resp got=%h exp=cf4", {rsp_valid, busy, rsp_id, rsp_err, rsp_data});
      end
      rsp_ready = 1;
      tick;
      rsp_ready = 0;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL spur_accept got=%b exp=00", {busy, rsp_valid});
      end
   endtask

   // transaction-level model: favoured id flips to the other one after each served op
   task automatic test_random;
      int n, d;
      logic [1:0] r;
      logic w, nf;
      logic [3:0] ea, eb;
      rst = 1; tick; rst = 0;
      nf = 0;
      for (int it = 0; it < 40; it++) begin
         r = 2'($urandom_range(1, 3));
         req0 = r[0]; req1 = r[1];
         a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         w = (r == 2'b11) ? nf : r[1];
         ea = w ? a1 : a0;
         eb = w ? b1 : b0;
         rsp_ready = 0;
         tick;
         checks++;
         if ({gnt0, gnt1} !== (w ? 2'b01 : 2'b10)) begin
            failures++;
            $display("FAIL rand_gnt%0d got=%b exp=%b", it, {gnt0, gnt1}, w ? 2'b01 : 2'b10);
         end
         req0 = 0; req1 = 0;
         a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
         wait_valid(n);
         checks++;
         if (n != 10 || {rsp_id, rsp_err, rsp_data} !== {w, 1'b0, prod(ea, eb)}) begin
            failures++;
            $display("FAIL rand_rsp%0d got=%h after %0d exp=%h after 10", it, {rsp_id, rsp_err, rsp_data}, n, {w, 1'b0, prod(ea, eb)});
         end
         d = $urandom_range(0, 3);
         repeat (d) tick;
         rsp_ready = 1;
         tick;
         rsp_ready = 0;
         checks++;
         if ({busy, rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rand_accept%0d got=%b exp=00", it, {busy, rsp_valid});
         end
         nf = ~w;
      end
   endtask

   initial begin
      rst = 1; req0 = 0; req1 = 0; rsp_ready = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      test_reset;
      test_single;
      test_both;
      test_hold;
      test_timeout;
      test_reset_wait;
      test_spurious;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Two-requester controller that shares one signed 4x4 multiplier (multiply_block) in the calculator datapath. It arbitrates round-robin between requesters and latches the winner's operands. It drives the multiplier's start pulse, holds the operands stable for the whole operation, and waits for the done pulse. It then returns the 8-bit product, tagged with the requester id, over a valid/ready response port, and reports an error if the multiplier never finishes.

Parameters:
TIMEOUT, 15, WAIT-state cycles allowed before the op is aborted with an error (must be at least 10)
CNT_W, 4, width of the timeout counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 request, level
a0  in  4  requester 0 operand A, two's complement
b0  in  4  requester 0 operand B, two's complement
gnt0  out  1  one-cycle pulse; operands a0/b0 captured
req1  in  1  requester 1 request, level
a1  in  4  requester 1 operand A
b1  in  4  requester 1 operand B
gnt1  out  1  one-cycle pulse; operands a1/b1 captured
mul_a  out  4  operand A to multiplier, held stable START..RESP
mul_b  out  4  operand B to multiplier, held stable START..RESP
mul_start  out  1  one-cycle start pulse to multiplier
mul_done  in  1  done pulse from multiplier
mul_c  in  8  product from multiplier, valid while mul_done=1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_data  out  8  signed product (0 on error)
rsp_err  out  1  timeout error flag
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high) applies on any clock edge with rst=1, including mid-operation. Effect:
  - state=IDLE; every output is 0 (gnt0/1, mul_a, mul_b, mul_start, rsp_*, busy).
  - The round-robin pointer favours requester 0 next.
  - The timeout counter is cleared.
  - An in-flight response is discarded; the multiplier shares rst.
- All outputs are registered.
- IDLE:
  - A request is sampled on each edge.
  - If only one of req0/req1 is high, that requester wins.
  - If both are high, the requester not served last wins (after reset, requester 0).
  - On the winning edge: mul_a/mul_b load the winner's operands, owner id is latched, gntN=1, go to START.
  - With no request, stay in IDLE.
- START (exactly 1 cycle):
  - mul_start=1 and gntN=1 in this cycle.
  - Requester may drop req and change operands from the next cycle.
  - Timeout counter cleared; go to WAIT.
- WAIT:
  - mul_start=0; the counter increments each cycle.
  - If mul_done=1: rsp_data<=mul_c, rsp_err<=0, rsp_id<=owner, rsp_valid<=1, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_data<=0, rsp_err<=1, rsp_id<=owner, rsp_valid<=1, go to RESP.
  - If mul_done and timeout coincide, done wins (no error).
- RESP:
  - rsp_* held stable while rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid<=0, rsp_err<=0, the round-robin pointer records owner as last served, go to IDLE.
  - rsp_ready already high on the first RESP cycle completes in that cycle.
- mul_done outside WAIT is ignored.
- Operands stay on mul_a/mul_b until the next grant; the multiplier samples a/b live during its shift phase.
- Latency (multiplier raises done 9 cycles after start):
  - request sampled at edge E0;
  - mul_start high in cycle E0+1;
  - mul_done in cycle E0+10;
  - rsp_valid high from cycle E0+11.
- Back-to-back: after the response is accepted there is at least one IDLE cycle before the next grant. Minimum period is 12 cycles per op.
- A request asserted while busy is held off, with no gnt, until IDLE; it is not lost as long as req stays high.
- rsp_data is the multiplier output passed through unchanged; the controller performs no arithmetic.

Test Plan:
1. Reset, then req0=1, a0=4'b1101 (-3), b0=4'b0101 (5), rsp_ready=1 -> gnt0 and mul_start 1 cycle after request; rsp_valid 11 cycles after request with rsp_id=0, rsp_data=8'hF1 (-15), rsp_err=0; busy falls after accept.
2. req0 and req1 both high from reset; req0 a=7,b=7; req1 a=-8 (4'h8), b=-8 -> first response id0 data 8'h31 (49); second response id1 data 8'h40 (64); grants alternate 0,1,0,1 while both stay high.
3. rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable for all 5 cycles; no new gnt while req1 is high; gnt1 appears after accept plus 1 IDLE cycle.
4. Multiplier replaced by a stub that never pulses mul_done -> rsp_valid exactly TIMEOUT cycles after entering WAIT, with rsp_err=1, rsp_data=0, correct rsp_id; next request is serviced normally.
5. rst=1 for 1 cycle during WAIT -> next cycle all outputs 0 and busy=0; stale mul_done ignored; req1 and req0 both high afterwards -> requester 0 granted first.
6. Spurious mul_done pulse in IDLE and in RESP -> no response change, no state change; req0 -> b0 changed right after gnt0 -> rsp_data still reflects the captured operands.
